servo_frame_tx: RTL

Serial transmitter sitting directly downstream of the servo position controller. Once per 20 ms servo frame it samples the controller's 16-bit status word (header, two position nibbles, direction bit, freeze bit), validates the header, and shifts it out MSB-first on a 3-wire SPI-style link (mode 0) to the external display/telemetry receiver. Unchanged words are suppressed except for a periodic refresh, and overruns and bad headers are counted.

---
 rtl/servo_pkg.sv | 35 +++
 rtl/servo_tx_baud.sv | 25 ++
 rtl/servo_frame_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo status-word transmitter.
package servo_pkg;

  // Status word layout
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned HDR_MSB    = 15;
  localparam int unsigned HDR_LSB    = 14;
  localparam int unsigned NIB_HI_MSB = 11;
  localparam int unsigned NIB_HI_LSB = 8;
  localparam int unsigned NIB_LO_MSB = 5;
  localparam int unsigned NIB_LO_LSB = 2;
  localparam int unsigned DIR_BIT    = 1;
  localparam int unsigned FRZ_BIT    = 0;

  localparam logic [1:0]  HDR_OK     = 2'b01;

  // Width of the saturating event counters and the refresh counter
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } tx_state_e;

  function automatic logic hdr_ok(input logic [WORD_W-1:0] w);
    return w[HDR_MSB:HDR_LSB] == HDR_OK;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/servo_tx_baud.sv
// Half-period strobe generator for the serial clock; counts only while enabled.
module servo_tx_baud
  import servo_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic en,
  output logic half_stb
);

  logic [CNT_W-1:0] cnt;

  assign half_stb = en && (cnt == CNT_W'(CLK_DIV - 1));

  // Free-run while enabled, parked at zero otherwise so every frame starts aligned
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (!en)      cnt <= '0;
    else if (half_stb) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/servo_frame_tx.sv
// Frame-rate sampler and MSB-first mode-0 serializer for the servo status word.
module servo_frame_tx
  import servo_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned REFRESH = 50
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data_in,
  input  logic              frame_tick,
  output logic              sclk,
  output logic              sdo,
  output logic              cs_n,
  output logic              busy,
  output logic              tx_done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  tx_state_e         state, state_nxt;
  logic [WORD_W-1:0] shreg, last_word;
  logic [CNT_W-1:0]  ref_cnt;
  logic [3:0]        bit_cnt;
  logic              sent;
  logic              stb;
  logic              tick_idle, good_hdr, want_send, send;
  logic              shift_fall, done;

  servo_tx_baud #(.CLK_DIV(CLK_DIV)) u_baud (
    .mclk     (mclk),
    .rst_n    (rst_n),
    .en       (state != ST_IDLE),
    .half_stb (stb)
  );

  assign sdo = shreg[WORD_W-1];

  // busy stays high through the tx_done cycle, so a tick there is a drop
  assign tick_idle = frame_tick && !busy;
  assign good_hdr  = hdr_ok(data_in);
  assign want_send = !sent || (data_in != last_word) || (ref_cnt == CNT_W'(REFRESH - 1));
  assign send      = tick_idle && good_hdr && want_send;

  // State register
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the strobes that step the datapath.
  // Bit 15 sits on sdo through SETUP and the first low phase before the first rise.
  always_comb begin
    state_nxt  = state;
    shift_fall = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (send) state_nxt = ST_SETUP;
      ST_SETUP: if (stb)  state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (stb && sclk) begin
          if (bit_cnt == 4'd0) state_nxt  = ST_HOLD;
          else                 shift_fall = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stb) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Link pins and frame handshake
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= done;
      if (send)         busy <= 1'b1;
      else if (tx_done) busy <= 1'b0;
      if (send)         cs_n <= 1'b0;
      else if (done)    cs_n <= 1'b1;
      if (state == ST_SHIFT && stb) sclk <= ~sclk;
    end
  end

  // Shift register and bit counter; advance only on falling sclk
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (send) begin
      shreg   <= data_in;
      bit_cnt <= 4'd15;
    end else if (shift_fall) begin
      shreg   <= {shreg[WORD_W-2:0], 1'b0};
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

  // Change suppression: remember the last word sent and ticks since then
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      last_word <= '0;
      ref_cnt   <= '0;
      sent      <= 1'b0;
    end else if (tick_idle && good_hdr) begin
      if (want_send) begin
        last_word <= data_in;
        ref_cnt   <= '0;
        sent      <= 1'b1;
      end else begin
        ref_cnt   <= ref_cnt + 1'b1;
      end
    end
  end

  // Saturating error and overrun counters
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (tick_idle && !good_hdr) err_cnt  <= sat_inc(err_cnt);
      if (frame_tick && busy)     drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule
